// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multi-cycle multiply/divide execute unit
// Holds the pipeline via stall while a MUL (1 cycle) or restoring DIV (32 cycles) runs.
module muldiv_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        en,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] r_q;
    logic        neg_q;
    logic        neg_r;

    logic        start;
    logic        is_div;
    logic        sgn_div;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_res;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sa;
    logic        sb;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] prod;
    logic [31:0] mul_res;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] r_n;
    logic [31:0] q_n;
    logic [31:0] div_res;

    // Reset gates start so stall reads 0 while RST is held low.
    assign start = RST && en && (op == 7'b0110011) && (funct7 == 7'b0000001)
                   && !flush && (state == IDLE);
    assign stall = !flush && (start || state == MUL || state == DIV);

    assign is_div   = funct3[2];
    assign sgn_div  = ~funct3[0];
    assign div_zero = (rs2_data == 32'd0);
    assign div_ovf  = sgn_div && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    assign special  = is_div && (div_zero || div_ovf);
    assign special_res = div_zero ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                                  : (funct3[1] ? 32'd0    : 32'h8000_0000);
    assign mag_a = (sgn_div && rs1_data[31]) ? -rs1_data : rs1_data;
    assign mag_b = (sgn_div && rs2_data[31]) ? -rs2_data : rs2_data;

    // 64-bit wrap of the sign-extended operands equals the low 64 bits of the 33x33 product.
    assign sa      = (f3_q[1:0] != 2'b11);
    assign sb      = ~f3_q[1];
    assign a64     = {{32{sa & a_q[31]}}, a_q};
    assign b64     = {{32{sb & b_q[31]}}, b_q};
    assign prod    = a64 * b64;
    assign mul_res = (f3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

    // a_q shifts out dividend bits and shifts in quotient bits.
    assign rem_sh  = {r_q, a_q[31]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign ge      = ~diff[32];
    assign r_n     = ge ? diff[31:0] : rem_sh[31:0];
    assign q_n     = {a_q[30:0], ge};
    assign div_res = f3_q[1] ? (neg_r ? -r_n : r_n) : (neg_q ? -q_n : q_n);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            f3_q         <= 3'd0;
            rd_q         <= 5'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            r_q          <= 32'd0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            result       <= 32'd0;
            rd_o         <= 5'd0;
            result_valid <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    f3_q  <= funct3;
                    rd_q  <= rd;
                    a_q   <= is_div ? mag_a : rs1_data;
                    b_q   <= is_div ? mag_b : rs2_data;
                    r_q   <= 32'd0;
                    neg_q <= is_div && sgn_div && (rs1_data[31] ^ rs2_data[31]);
                    neg_r <= is_div && sgn_div && rs1_data[31];
                    cnt   <= 5'd0;
                    if (special) begin
                        state        <= DONE;
                        result       <= special_res;
                        rd_o         <= rd;
                        result_valid <= 1'b1;
                    end else begin
                        state <= is_div ? DIV : MUL;
                    end
                end
                MUL: begin
                    state        <= DONE;
                    result       <= mul_res;
                    rd_o         <= rd_q;
                    result_valid <= 1'b1;
                end
                DIV: begin
                    a_q <= q_n;
                    r_q <= r_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state        <= DONE;
                        result       <= div_res;
                        rd_o         <= rd_q;
                        result_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic        CLK;
    logic        RST;
    logic        flush;
    logic        en;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    int          stalls;
    logic        seen_v;
    logic        seen_s;
    logic        stall_ok;

    muldiv_unit dut (
        .CLK(CLK), .RST(RST), .flush(flush), .en(en), .op(op), .funct3(funct3),
        .funct7(funct7), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
        .stall(stall), .result_valid(result_valid), .result(result), .rd_o(rd_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        en = 1'b1; op = 7'b0110011; funct7 = 7'b0000001;
        funct3 = f3; rs1_data = a; rs2_data = b; rd = r;
    endtask

    // Issue in the current cycle (cycle 0), hold the instruction until the completion
    // cycle, and report latency in cycles plus the number of cycles stall was high.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output logic [31:0] o_res,
                         output logic [4:0] o_rd, output int o_lat, output int o_stalls);
        drive(f3, a, b, r);
        o_lat = -1; o_stalls = 0; o_res = 32'hx; o_rd = 5'hx;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (stall) o_stalls++;
            if (result_valid) begin
                o_lat = c; o_res = result; o_rd = rd_o;
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", result_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result got=%h exp=0", result); end
        checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL rst_rd got=%h exp=0", rd_o); end
        RST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_non_m;
        seen_s = 1'b0; seen_v = 1'b0;
        en = 1'b1; op = 7'b0110011; funct7 = 7'b0000000; funct3 = 3'b000;
        rs1_data = 32'd3; rs2_data = 32'd4; rd = 5'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            seen_s |= stall; seen_v |= result_valid;
            @(posedge CLK); #1;
            if (i == 2) begin op = 7'b0010011; funct7 = 7'b0000001; end
            if (i == 5) begin op = 7'b0110011; en = 1'b0; end
        end
        en = 1'b0;
        checks++; if (seen_s !== 1'b0) begin errors++; $display("FAIL nonm_stall got=%b exp=0", seen_s); end
        checks++; if (seen_v !== 1'b0) begin errors++; $display("FAIL nonm_valid got=%b exp=0", seen_v); end
    endtask

    task automatic test_mul;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_res got=%h exp=ffffffeb", res); end
        checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rd got=%0d exp=5", rdo); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL mul_lat got=%0d exp=2", lat); end
        checks++; if (stalls !== 2) begin errors++; $display("FAIL mul_stalls got=%0d exp=2", stalls); end
        @(negedge CLK);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mul_pulse got=%b exp=0", result_valid); end
        checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_hold got=%h exp=ffffffeb", result); end
        @(posedge CLK); #1;
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, res, rdo, lat, stalls);
        checks++; if (res !== 32'h4000_0000 || lat !== 2) begin errors++; $display("FAIL mulh got=%h/%0d exp=40000000/2", res, lat); end
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFFE || lat !== 2) begin errors++; $display("FAIL mulhu got=%h/%0d exp=fffffffe/2", res, lat); end
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFFF || lat !== 2) begin errors++; $display("FAIL mulhsu got=%h/%0d exp=ffffffff/2", res, lat); end
    endtask

    task automatic test_div;
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_res got=%h exp=fffffffd", res); end
        checks++; if (lat !== 33 || stalls !== 33) begin errors++; $display("FAIL div_timing got=%0d/%0d exp=33/33", lat, stalls); end
        checks++; if (rdo !== 5'd10) begin errors++; $display("FAIL div_rd got=%0d exp=10", rdo); end
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_res got=%h exp=ffffffff", res); end
        checks++; if (lat !== 33 || stalls !== 33) begin errors++; $display("FAIL rem_timing got=%0d/%0d exp=33/33", lat, stalls); end
        do_op(3'b101, 32'd100, 32'd7, 5'd12, res, rdo, lat, stalls);
        checks++; if (res !== 32'd14 || lat !== 33) begin errors++; $display("FAIL divu got=%h/%0d exp=e/33", res, lat); end
        do_op(3'b111, 32'd100, 32'd7, 5'd13, res, rdo, lat, stalls);
        checks++; if (res !== 32'd2 || lat !== 33) begin errors++; $display("FAIL remu got=%h/%0d exp=2/33", res, lat); end
    endtask

    task automatic test_div_special;
        do_op(3'b101, 32'd5, 32'd0, 5'd20, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_res got=%h exp=ffffffff", res); end
        checks++; if (lat !== 1 || stalls !== 1) begin errors++; $display("FAIL divu0_timing got=%0d/%0d exp=1/1", lat, stalls); end
        checks++; if (rdo !== 5'd20) begin errors++; $display("FAIL divu0_rd got=%0d exp=20", rdo); end
        do_op(3'b110, 32'd5, 32'd0, 5'd21, res, rdo, lat, stalls);
        checks++; if (res !== 32'd5 || lat !== 1) begin errors++; $display("FAIL rem0 got=%h/%0d exp=5/1", res, lat); end
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, res, rdo, lat, stalls);
        checks++; if (res !== 32'h8000_0000 || lat !== 1) begin errors++; $display("FAIL divovf got=%h/%0d exp=80000000/1", res, lat); end
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, res, rdo, lat, stalls);
        checks++; if (res !== 32'd0 || lat !== 1) begin errors++; $display("FAIL removf got=%h/%0d exp=0/1", res, lat); end
    endtask

    task automatic test_flush;
        do_op(3'b000, 32'd6, 32'd7, 5'd3, res, rdo, lat, stalls);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL flush_pre got=%h exp=2a", res); end
        drive(3'b100, 32'd1000, 32'd3, 5'd12);
        seen_v = 1'b0; stall_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            seen_v |= result_valid; stall_ok &= stall;
            @(posedge CLK); #1;
        end
        flush = 1'b1;
        @(negedge CLK);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        @(posedge CLK); #1;
        flush = 1'b0; en = 1'b0;
        @(negedge CLK);
        seen_v |= result_valid;
        checks++; if (stall_ok !== 1'b1) begin errors++; $display("FAIL flush_prestall got=%b exp=1", stall_ok); end
        checks++; if (stall !== 1'b0 || seen_v !== 1'b0) begin errors++; $display("FAIL flush_idle got=%b%b exp=00", stall, seen_v); end
        checks++; if (result !== 32'd42 || rd_o !== 5'd3) begin errors++; $display("FAIL flush_hold got=%h/%0d exp=2a/3", result, rd_o); end
        @(posedge CLK); #1;
        do_op(3'b101, 32'd100, 32'd7, 5'd14, res, rdo, lat, stalls);
        checks++; if (res !== 32'd14 || rdo !== 5'd14 || lat !== 33) begin errors++; $display("FAIL flush_after got=%h/%0d/%0d exp=e/14/33", res, rdo, lat); end
    endtask

    task automatic test_reset_mid;
        drive(3'b101, 32'd100, 32'd7, 5'd9);
        repeat (5) begin
            @(negedge CLK);
            @(posedge CLK); #1;
        end
        #2 RST = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got=%b%b exp=00", stall, result_valid); end
        checks++; if (result !== 32'd0 || rd_o !== 5'd0) begin errors++; $display("FAIL rstmid_data got=%h/%0d exp=0/0", result, rd_o); end
        en = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        seen_s = 1'b0; seen_v = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            seen_s |= stall; seen_v |= result_valid;
        end
        @(posedge CLK); #1;
        checks++; if (seen_s !== 1'b0 || seen_v !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%b%b exp=00", seen_s, seen_v); end
    endtask

    task automatic test_back_to_back;
        do_op(3'b000, 32'd3, 32'd5, 5'd1, res, rdo, lat, stalls);
        checks++; if (res !== 32'd15 || lat !== 2) begin errors++; $display("FAIL b2b_first got=%h/%0d exp=f/2", res, lat); end
        do_op(3'b000, 32'h0000_FFFF, 32'h0001_0001, 5'd2, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFFF || rdo !== 5'd2 || lat !== 2) begin errors++; $display("FAIL b2b_second got=%h/%0d/%0d exp=ffffffff/2/2", res, rdo, lat); end
        do_op(3'b101, 32'd9, 32'd0, 5'd4, res, rdo, lat, stalls);
        checks++; if (res !== 32'hFFFF_FFFF || lat !== 1) begin errors++; $display("FAIL b2b_third got=%h/%0d exp=ffffffff/1", res, lat); end
    endtask

    initial begin
        RST = 1'b0; flush = 1'b0; en = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; rd = 5'd0;
        test_reset;
        test_non_m;
        test_mul;
        test_div;
        test_div_special;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
